// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
package hazard_pkg;

  // Controller FSM: free-running pipeline or frozen on a slow data-memory access
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // EX operand source select
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  // Decode constants shared with the control unit
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [1:0] RUDATA_MEM = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-register taps and hazard control strobes
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic [4:0]       id_rs1, id_rs2;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic             ex_ruwr, ex_is_load, ex_br_taken;
  logic [4:0]       mem_rd;
  logic             mem_ruwr, mem_dm_access, dm_ready;
  logic [4:0]       wb_rd;
  logic             wb_ruwr;

  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, memwb_en, memwb_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             dm_err;
  logic [CNT_W-1:0] stall_count, flush_count;

  // Pipeline side: drives register indices/control bits, receives strobes
  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_ruwr, ex_is_load, ex_br_taken,
           mem_rd, mem_ruwr, mem_dm_access, dm_ready, wb_rd, wb_ruwr,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
           memwb_flush, fwd_a, fwd_b, dm_err, stall_count, flush_count
  );

  // Hazard controller side
  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_ruwr, ex_is_load, ex_br_taken,
           mem_rd, mem_ruwr, mem_dm_access, dm_ready, wb_rd, wb_ruwr,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
           memwb_flush, fwd_a, fwd_b, dm_err, stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// rtl/pipeline_hazard_ctrl_fwd_unit.sv - EX operand forwarding comparator
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_ruwr_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_ruwr_i,
  output fwd_sel_t   sel_o
);

  // MEM holds the younger result so it wins over WB; x0 is hardwired zero
  always_comb begin
    sel_o = FWD_RF;
    if (mem_ruwr_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_ruwr_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward controller for the 5-stage RV32I pipeline
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             dm_err_q;

  logic     load_use, release_c, timeout_c, stall_inc, flush_inc;
  logic     freeze_c, pc_en_c, ifid_en_c, idex_en_c;
  logic     ifid_flush_c, idex_flush_c, memwb_flush_c;
  fwd_sel_t fwd_a_c, fwd_b_c;

  fwd_unit u_fwd_a (
    .rs_i(hz.ex_rs1), .mem_rd_i(hz.mem_rd), .mem_ruwr_i(hz.mem_ruwr),
    .wb_rd_i(hz.wb_rd), .wb_ruwr_i(hz.wb_ruwr), .sel_o(fwd_a_c)
  );

  fwd_unit u_fwd_b (
    .rs_i(hz.ex_rs2), .mem_rd_i(hz.mem_rd), .mem_ruwr_i(hz.mem_ruwr),
    .wb_rd_i(hz.wb_rd), .wb_ruwr_i(hz.wb_ruwr), .sel_o(fwd_b_c)
  );

  // rs2 is compared even for I-type: a spurious stall is cheaper than decoding format here
  assign load_use = hz.ex_is_load && hz.ex_ruwr && (hz.ex_rd != 5'd0) &&
                    ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

  // Next-state and strobe decode; a released or timed-out wait falls through to the RUN rules
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    release_c     = 1'b0;
    timeout_c     = 1'b0;
    freeze_c      = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    idex_en_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    memwb_flush_c = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.mem_dm_access && !hz.dm_ready) begin
          freeze_c  = 1'b1;
          stall_inc = 1'b1;
          wait_d    = WCNT_W'(1);
          state_d   = MEM_WAIT;
        end else begin
          release_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.dm_ready) begin
          release_c = 1'b1;
          state_d   = RUN;
        end else if (wait_q == WCNT_W'(MEM_TIMEOUT)) begin
          release_c = 1'b1;
          timeout_c = 1'b1;
          state_d   = RUN;
        end else begin
          freeze_c  = 1'b1;
          stall_inc = 1'b1;
          wait_d    = wait_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (release_c) begin
      // A taken branch squashes the dependent ID instruction, so it outranks load-use
      if (hz.ex_br_taken) begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        flush_inc    = 1'b1;
      end else if (load_use) begin
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        idex_flush_c = 1'b1;
        stall_inc    = 1'b1;
      end
    end
    // The timed-out access must not reach the register file
    if (timeout_c) memwb_flush_c = 1'b1;
    if (freeze_c) begin
      pc_en_c   = 1'b0;
      ifid_en_c = 1'b0;
      idex_en_c = 1'b0;
    end
  end

  // FSM, wait counter, saturating counters and registered error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      wait_q   <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
      dm_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      dm_err_q <= timeout_c;
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.pc_en       = !rst && pc_en_c;
  assign hz.ifid_en     = !rst && ifid_en_c;
  assign hz.idex_en     = !rst && idex_en_c;
  assign hz.exmem_en    = !rst && !freeze_c;
  assign hz.memwb_en    = !rst && !freeze_c;
  assign hz.ifid_flush  = rst || ifid_flush_c;
  assign hz.idex_flush  = rst || idex_flush_c;
  assign hz.memwb_flush = rst || memwb_flush_c;
  assign hz.fwd_a       = rst ? FWD_RF : fwd_a_c;
  assign hz.fwd_b       = rst ? FWD_RF : fwd_b_c;
  assign hz.dm_err      = dm_err_q;
  assign hz.stall_count = stall_q;
  assign hz.flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) ifa ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  ifb ();

  assign ifb.id_rs1        = ifa.id_rs1;
  assign ifb.id_rs2        = ifa.id_rs2;
  assign ifb.ex_rs1        = ifa.ex_rs1;
  assign ifb.ex_rs2        = ifa.ex_rs2;
  assign ifb.ex_rd         = ifa.ex_rd;
  assign ifb.ex_ruwr       = ifa.ex_ruwr;
  assign ifb.ex_is_load    = ifa.ex_is_load;
  assign ifb.ex_br_taken   = ifa.ex_br_taken;
  assign ifb.mem_rd        = ifa.mem_rd;
  assign ifb.mem_ruwr      = ifa.mem_ruwr;
  assign ifb.mem_dm_access = ifa.mem_dm_access;
  assign ifb.dm_ready      = ifa.dm_ready;
  assign ifb.wb_rd         = ifa.wb_rd;
  assign ifb.wb_ruwr       = ifa.wb_ruwr;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz(ifa.slave));
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .hz(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifa.id_rs1 = 5'd0; ifa.id_rs2 = 5'd0;
    ifa.ex_rs1 = 5'd0; ifa.ex_rs2 = 5'd0; ifa.ex_rd = 5'd0;
    ifa.ex_ruwr = 1'b0; ifa.ex_is_load = 1'b0; ifa.ex_br_taken = 1'b0;
    ifa.mem_rd = 5'd0; ifa.mem_ruwr = 1'b0; ifa.mem_dm_access = 1'b0; ifa.dm_ready = 1'b0;
    ifa.wb_rd = 5'd0; ifa.wb_ruwr = 1'b0;
  endtask

  task automatic set_load_use();
    ifa.ex_is_load = 1'b1; ifa.ex_ruwr = 1'b1; ifa.ex_rd = 5'd7; ifa.id_rs2 = 5'd7;
  endtask

  initial begin
    clear_inputs();
    // Reset: a live MEM match must still read as RF while rst is high
    ifa.mem_rd = 5'd5; ifa.mem_ruwr = 1'b1; ifa.ex_rs1 = 5'd5;
    #2;
    chk("rst_pc_en",       32'(ifa.pc_en), 0);
    chk("rst_exmem_en",    32'(ifa.exmem_en), 0);
    chk("rst_ifid_flush",  32'(ifa.ifid_flush), 1);
    chk("rst_idex_flush",  32'(ifa.idex_flush), 1);
    chk("rst_memwb_flush", 32'(ifa.memwb_flush), 1);
    chk("rst_fwd_a",       32'(ifa.fwd_a), 0);
    chk("rst_stall",       32'(ifa.stall_count), 0);
    chk("rst_flush",       32'(ifa.flush_count), 0);
    chk("rst_dm_err",      32'(ifa.dm_err), 0);
    tick();
    rst = 1'b0;

    // Forwarding priority and x0 suppression
    ifa.wb_rd = 5'd5; ifa.wb_ruwr = 1'b1; ifa.ex_rs2 = 5'd6;
    #1;
    chk("fwd_a_mem",     32'(ifa.fwd_a), 1);
    chk("fwd_b_none",    32'(ifa.fwd_b), 0);
    chk("run_pc_en",     32'(ifa.pc_en), 1);
    ifa.mem_ruwr = 1'b0;
    #1;
    chk("fwd_a_wb",      32'(ifa.fwd_a), 2);
    ifa.wb_rd = 5'd6; ifa.mem_rd = 5'd6; ifa.mem_ruwr = 1'b1; ifa.ex_rs1 = 5'd6;
    #1;
    chk("fwd_b_mem_wins", 32'(ifa.fwd_b), 1);
    ifa.mem_rd = 5'd0; ifa.wb_rd = 5'd0; ifa.ex_rs1 = 5'd0; ifa.ex_rs2 = 5'd0;
    #1;
    chk("fwd_a_x0",      32'(ifa.fwd_a), 0);
    chk("fwd_b_x0",      32'(ifa.fwd_b), 0);

    // Load-use: one bubble cycle
    tick();
    clear_inputs();
    set_load_use();
    #1;
    chk("lu_pc_en",      32'(ifa.pc_en), 0);
    chk("lu_ifid_en",    32'(ifa.ifid_en), 0);
    chk("lu_idex_en",    32'(ifa.idex_en), 1);
    chk("lu_idex_flush", 32'(ifa.idex_flush), 1);
    chk("lu_memwb_en",   32'(ifa.memwb_en), 1);
    tick();
    clear_inputs();
    #1;
    chk("lu_after_pc_en",  32'(ifa.pc_en), 1);
    chk("lu_after_flush",  32'(ifa.idex_flush), 0);
    chk("lu_stall_count",  32'(ifa.stall_count), 1);

    // Taken branch overrides a simultaneous load-use
    set_load_use();
    ifa.ex_br_taken = 1'b1;
    #1;
    chk("br_pc_en",      32'(ifa.pc_en), 1);
    chk("br_ifid_flush", 32'(ifa.ifid_flush), 1);
    chk("br_idex_flush", 32'(ifa.idex_flush), 1);
    tick();
    clear_inputs();
    #1;
    chk("br_flush_count", 32'(ifa.flush_count), 1);
    chk("br_stall_count", 32'(ifa.stall_count), 1);

    // Memory wait: three frozen cycles, released on the fourth
    ifa.mem_dm_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_pc_en",      32'(ifa.pc_en), 0);
      chk("mw_memwb_en",   32'(ifa.memwb_en), 0);
      chk("mw_ifid_flush", 32'(ifa.ifid_flush), 0);
      tick();
    end
    ifa.dm_ready = 1'b1;
    #1;
    chk("mw_rel_pc_en",    32'(ifa.pc_en), 1);
    chk("mw_rel_exmem_en", 32'(ifa.exmem_en), 1);
    chk("mw_rel_memwb_fl", 32'(ifa.memwb_flush), 0);
    tick();
    clear_inputs();
    #1;
    chk("mw_stall_count",  32'(ifa.stall_count), 4);
    chk("mw_dm_err",       32'(ifa.dm_err), 0);
    chk("mw_state_run",    32'(ifa.pc_en), 1);

    // Timeout with a taken branch held in EX throughout the freeze
    ifa.mem_dm_access = 1'b1; ifa.ex_br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_frozen_pc_en", 32'(ifa.pc_en), 0);
      chk("to_frozen_ifid_flush", 32'(ifa.ifid_flush), 0);
      tick();
    end
    #1;
    chk("to_pc_en",       32'(ifa.pc_en), 1);
    chk("to_memwb_en",    32'(ifa.memwb_en), 1);
    chk("to_memwb_flush", 32'(ifa.memwb_flush), 1);
    chk("to_ifid_flush",  32'(ifa.ifid_flush), 1);
    chk("to_dm_err_early", 32'(ifa.dm_err), 0);
    tick();
    clear_inputs();
    #1;
    chk("to_dm_err",      32'(ifa.dm_err), 1);
    chk("to_state_run",   32'(ifa.pc_en), 1);
    chk("to_stall_count", 32'(ifa.stall_count), 8);
    chk("to_flush_count", 32'(ifa.flush_count), 2);
    chk("sat_stall_pre",  32'(ifb.stall_count), 3);
    tick();
    chk("to_dm_err_pulse", 32'(ifa.dm_err), 0);

    // Reset mid-wait aborts without an error pulse
    ifa.mem_dm_access = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rw_pc_en",   32'(ifa.pc_en), 0);
    chk("rw_stall",   32'(ifa.stall_count), 0);
    chk("rw_flush",   32'(ifa.flush_count), 0);
    tick();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("rw_state_run", 32'(ifa.pc_en), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rw_no_dm_err", 32'(ifa.dm_err), 0);
    end

    // Five load-use stalls: full width counts them, 2-bit counter saturates
    set_load_use();
    for (int i = 0; i < 5; i++) tick();
    clear_inputs();
    #1;
    chk("sat_wide_stall", 32'(ifa.stall_count), 5);
    chk("sat_stall",      32'(ifb.stall_count), 3);
    chk("sat_flush",      32'(ifb.flush_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Consumes register indices and the decoded control bits (RUWr, RUDATAWrSrc, DMWr) carried in the pipeline registers.
- Produces per-stage enable/flush strobes and EX-operand forwarding selects.
- Owns a small FSM that freezes the pipeline while the data memory is not ready, with a timeout and saturating stall/flush counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before abort (≥2)
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
ex_rs1  in  5  rs1 of instruction in EX
ex_rs2  in  5  rs2 of instruction in EX
ex_rd  in  5  rd in EX
ex_ruwr  in  1  RUWr in EX
ex_is_load  in  1  EX instr is a load (RUDATAWrSrc==2'b01)
ex_br_taken  in  1  branch/jump in EX resolved taken
mem_rd  in  5  rd in MEM
mem_ruwr  in  1  RUWr in MEM
mem_dm_access  in  1  MEM instr is a load or store
dm_ready  in  1  data memory completes access this cycle
wb_rd  in  5  rd in WB
wb_ruwr  in  1  RUWr in WB
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID load bubble
idex_en  out  1  ID/EX register enable
idex_flush  out  1  ID/EX load bubble
exmem_en  out  1  EX/MEM register enable
memwb_en  out  1  MEM/WB register enable
memwb_flush  out  1  MEM/WB load bubble
fwd_a  out  2  EX operand A select
fwd_b  out  2  EX operand B select
dm_err  out  1  one-cycle pulse on memory timeout
stall_count  out  CNT_W  saturating count of stall cycles
flush_count  out  CNT_W  saturating count of flush events

Behaviour:
- Reset (rst high, async): state=RUN, wait counter=0, dm_err=0, stall_count=0, flush_count=0.
- While rst is high: all *_en=0, ifid_flush=idex_flush=memwb_flush=1, fwd_a=fwd_b=00.
- Forwarding (combinational, valid in any state):
  - fwd_a=01 if mem_ruwr && mem_rd!=0 && mem_rd==ex_rs1.
  - Else fwd_a=10 if wb_ruwr && wb_rd!=0 && wb_rd==ex_rs1.
  - Else fwd_a=00.
  - fwd_b is identical using ex_rs2. MEM beats WB; x0 is never forwarded.
- load_use = ex_is_load && ex_ruwr && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2). Conservative: rs2 compared even for I-type.
- FSM states: RUN, MEM_WAIT.
- RUN, priority high→low:
  1. mem_dm_access && !dm_ready: all *_en=0, no flushes. Next=MEM_WAIT, wait counter←1, stall_count++.
  2. ex_br_taken: all en=1, ifid_flush=idex_flush=1, flush_count++. Overrides load_use, because the dependent ID instruction is squashed.
  3. load_use: pc_en=ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1, stall_count++.
  4. Otherwise: all en=1, no flushes.
- MEM_WAIT: all en=0, stall_count++ every cycle.
  - dm_ready=1: evaluate the RUN rules for this cycle as if state were RUN with the access complete. Next=RUN.
  - Wait counter reaches MEM_TIMEOUT with dm_ready=0: dm_err=1 for one cycle. Pipeline advances as in RUN, but memwb_flush=1 so the faulty access is not written back. Next=RUN.
- A taken branch seen while frozen is not lost: EX is held, so it is re-evaluated when the pipeline is released.
- Counters saturate at 2^CNT_W-1 and never wrap. A single cycle increments each counter at most once.
- dm_err is registered; all other outputs are combinational from state and inputs.
- rst asserted mid-wait aborts the wait immediately. No dm_err is produced.

Decomposition:
- Shared package hazard_pkg:
  - state enum {RUN, MEM_WAIT}.
  - fwd_sel_t localparams FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - OP_LOAD=7'b0000011 and RUDATA_MEM=2'b01, shared with the control unit.
- Sub-module fwd_unit: pure combinational forwarding comparator, instantiated once for operand A and once for B.

Test Plan:
- RAW: add x5 in MEM (mem_rd=5, mem_ruwr=1) and wb_rd=5 with wb_ruwr=1; ex_rs1=5 → fwd_a=01. Drop mem_ruwr → fwd_a=10. Set rd=0 → fwd_a=00.
- Load-use: ex_is_load=1, ex_rd=7, id_rs2=7 → exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_count 0→1.
- Branch plus load_use same cycle: ex_br_taken=1 → ifid_flush=idex_flush=1, pc_en=1, flush_count +1, stall_count unchanged.
- Memory wait: mem_dm_access=1, dm_ready low for 3 cycles then high → enables 0 for 3 cycles, all 1 on the 4th, stall_count=3, dm_err never set.
- Timeout at MEM_TIMEOUT=4 with dm_ready held low → dm_err pulses one cycle after the 4th wait cycle, memwb_flush=1, state returns to RUN.
- Saturation: CNT_W=2, 5 load-use stalls → stall_count=3. rst asserted mid-MEM_WAIT → state=RUN, counters=0, no dm_err.
